// File: rtl/upd_slow_phy_to_llr_gen.sv
// Slow-path LLR input generator: splits wide IQ FIFO words into LANES-wide RE beats and pairs
// each RE with a noise value shared by groups of `rate` consecutive REs.
module upd_slow_phy_to_llr_gen #(
    parameter int unsigned DW          = 16,
    parameter int unsigned IQ_WORDS    = 8,
    parameter int unsigned NOISE_WORDS = 8,
    parameter int unsigned LANES       = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                      i_core_clk,
    input  logic                      i_rx_rst,
    input  logic                      i_start,
    input  logic [CNT_W-1:0]          i_user_iq_noise_rate,
    input  logic [CNT_W-1:0]          i_cur_user_re_amounts,
    input  logic [IQ_WORDS*DW-1:0]    i_iq_data,
    input  logic [NOISE_WORDS*DW-1:0] i_noise_data,
    input  logic                      i_iq_fifo_empty,
    input  logic                      i_noise_fifo_empty,
    output logic                      o_iq_fifo_rd_en,
    output logic                      o_noise_fifo_rd_en,
    input  logic                      i_out_ready,
    output logic                      o_data_strobe,
    output logic [LANES*DW-1:0]       o_re_data_i,
    output logic [LANES*DW-1:0]       o_re_data_q,
    output logic [LANES*DW-1:0]       o_noise_data,
    output logic [LANES-1:0]          o_re_valid,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_start_err
);
    localparam int RES_PER_WORD = int'(IQ_WORDS) / 2;
    localparam int NW           = int'(NOISE_WORDS);
    localparam int NL           = int'(LANES);
    localparam int BPW          = RES_PER_WORD / NL;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]               r_state;
    logic [CNT_W-1:0]         r_amounts;
    logic [CNT_W-1:0]         r_rate;
    logic [CNT_W-1:0]         r_re_cnt;
    logic [CNT_W-1:0]         r_rate_cnt;
    logic [CNT_W-1:0]         r_noise_pos;
    logic [CNT_W-1:0]         r_beat_idx;
    logic [NOISE_WORDS*DW-1:0] r_hold;
    logic                     r_strobe;
    logic [LANES*DW-1:0]      r_i;
    logic [LANES*DW-1:0]      r_q;
    logic [LANES*DW-1:0]      r_n;
    logic [LANES-1:0]         r_valid;
    logic                     r_done;
    logic                     r_start_err;

    logic                     w_remain;
    logic                     w_last_beat;
    logic                     w_need_next;
    logic                     w_load;
    logic                     w_iq_pop;
    logic                     w_accept_last;
    logic [LANES*DW-1:0]      w_i;
    logic [LANES*DW-1:0]      w_q;
    logic [LANES*DW-1:0]      w_n;
    logic [LANES-1:0]         w_valid;
    logic [CNT_W-1:0]         w_rate_cnt_nxt;
    logic [CNT_W-1:0]         w_noise_pos_nxt;

    // Walk the lanes in order, advancing the noise position once every `rate` valid REs.
    // A position at or beyond NW belongs to the next noise word, i.e. the FIFO head.
    always_comb begin
        int pos;
        int cnt;
        int re_idx;
        w_remain    = (r_re_cnt < r_amounts);
        w_last_beat = ({1'b0, r_re_cnt} + (CNT_W+1)'(NL)) >= {1'b0, r_amounts};
        w_need_next = 1'b0;
        w_i         = '0;
        w_q         = '0;
        w_n         = '0;
        w_valid     = '0;
        pos         = int'(r_noise_pos);
        cnt         = int'(r_rate_cnt);
        re_idx      = 0;
        for (int k = 0; k < NL; k++) begin
            if (int'(r_re_cnt) + k < int'(r_amounts)) begin
                w_valid[k] = 1'b1;
                re_idx     = int'(r_beat_idx) * NL + k;
                for (int j = 0; j < RES_PER_WORD; j++) begin
                    if (j == re_idx) begin
                        w_i[k*DW +: DW] = i_iq_data[2*j*DW +: DW];
                        w_q[k*DW +: DW] = i_iq_data[(2*j+1)*DW +: DW];
                    end
                end
                if (pos >= NW) begin
                    w_need_next = 1'b1;
                    for (int j = 0; j < NW; j++) begin
                        if (j == pos - NW) w_n[k*DW +: DW] = i_noise_data[j*DW +: DW];
                    end
                end else begin
                    for (int j = 0; j < NW; j++) begin
                        if (j == pos) w_n[k*DW +: DW] = r_hold[j*DW +: DW];
                    end
                end
                cnt = cnt + 1;
                if (cnt >= int'(r_rate)) begin
                    cnt = 0;
                    pos = pos + 1;
                end
            end
        end
        w_rate_cnt_nxt  = CNT_W'(cnt);
        w_noise_pos_nxt = CNT_W'(w_need_next ? pos - NW : pos);
    end

    assign w_load = !i_rx_rst && (r_state == S_RUN) && (!r_strobe || i_out_ready) &&
                    !i_iq_fifo_empty && w_remain && (!w_need_next || !i_noise_fifo_empty);
    assign w_iq_pop      = w_load && ((r_beat_idx == CNT_W'(BPW - 1)) || w_last_beat);
    assign w_accept_last = (r_state == S_RUN) && r_strobe && i_out_ready && !w_remain;

    assign o_iq_fifo_rd_en    = w_iq_pop;
    assign o_noise_fifo_rd_en = !i_rx_rst && !i_noise_fifo_empty &&
                                ((r_state == S_LOAD) || (w_load && w_need_next));
    assign o_data_strobe = r_strobe;
    assign o_re_data_i   = r_i;
    assign o_re_data_q   = r_q;
    assign o_noise_data  = r_n;
    assign o_re_valid    = r_valid;
    assign o_busy        = (r_state == S_LOAD) || (r_state == S_RUN);
    assign o_done        = r_done;
    assign o_start_err   = r_start_err;

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            r_state     <= S_IDLE;
            r_amounts   <= '0;
            r_rate      <= '0;
            r_re_cnt    <= '0;
            r_rate_cnt  <= '0;
            r_noise_pos <= '0;
            r_beat_idx  <= '0;
            r_hold      <= '0;
            r_strobe    <= 1'b0;
            r_i         <= '0;
            r_q         <= '0;
            r_n         <= '0;
            r_valid     <= '0;
            r_done      <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_start_err <= i_start && (r_state != S_IDLE);
            r_done      <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_amounts   <= i_cur_user_re_amounts;
                        r_rate      <= (i_user_iq_noise_rate == '0) ? CNT_W'(1)
                                                                   : i_user_iq_noise_rate;
                        r_re_cnt    <= '0;
                        r_rate_cnt  <= '0;
                        r_noise_pos <= '0;
                        r_beat_idx  <= '0;
                        r_state     <= (i_cur_user_re_amounts == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (!i_noise_fifo_empty) begin
                        r_hold  <= i_noise_data;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept_last) r_state <= S_DONE;
                end
                default: begin
                    r_hold  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
            if (w_load) begin
                r_strobe    <= 1'b1;
                r_i         <= w_i;
                r_q         <= w_q;
                r_n         <= w_n;
                r_valid     <= w_valid;
                r_re_cnt    <= w_last_beat ? r_amounts : r_re_cnt + CNT_W'(NL);
                r_rate_cnt  <= w_rate_cnt_nxt;
                r_noise_pos <= w_noise_pos_nxt;
                r_beat_idx  <= w_iq_pop ? '0 : r_beat_idx + CNT_W'(1);
                if (w_need_next) r_hold <= i_noise_data;
            end else if (i_out_ready) begin
                r_strobe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_upd_slow_phy_to_llr_gen.sv
// Directed bench for upd_slow_phy_to_llr_gen: FIFO models feed word-tagged data and every
// presented beat is compared against an RE-indexed reference.
module tb_upd_slow_phy_to_llr_gen;
    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   rate;
    logic [15:0]   amt;
    logic [127:0]  iq_data;
    logic [127:0]  noise_data;
    logic          iq_empty;
    logic          noise_empty;
    logic          iq_rd;
    logic          n_rd;
    logic          ready;
    logic          strobe;
    logic [31:0]   oi;
    logic [31:0]   oq;
    logic [31:0]   on;
    logic [1:0]    ov;
    logic          busy;
    logic          done;
    logic          serr;

    int iq_ptr = 0;
    int n_ptr  = 0;
    int checks = 0;
    int errors = 0;

    logic [31:0] b0_i, b0_q, b0_n, b1_i, b1_n;
    logic [1:0]  b0_v, b1_v;

    logic [7:0] pat [0:7] = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};

    upd_slow_phy_to_llr_gen dut (
        .i_core_clk            (clk),
        .i_rx_rst              (rst),
        .i_start               (start),
        .i_user_iq_noise_rate  (rate),
        .i_cur_user_re_amounts (amt),
        .i_iq_data             (iq_data),
        .i_noise_data          (noise_data),
        .i_iq_fifo_empty       (iq_empty),
        .i_noise_fifo_empty    (noise_empty),
        .o_iq_fifo_rd_en       (iq_rd),
        .o_noise_fifo_rd_en    (n_rd),
        .i_out_ready           (ready),
        .o_data_strobe         (strobe),
        .o_re_data_i           (oi),
        .o_re_data_q           (oq),
        .o_noise_data          (on),
        .o_re_valid            (ov),
        .o_busy                (busy),
        .o_done                (done),
        .o_start_err           (serr)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] smp(input int w, input int s);
        logic [7:0] wb;
        wb = w[7:0];
        return {wb, pat[s]};
    endfunction

    always_comb begin
        for (int s = 0; s < 8; s++) begin
            iq_data[s*16 +: 16]    = smp(iq_ptr, s);
            noise_data[s*16 +: 16] = smp(n_ptr, s);
        end
    end

    always @(posedge clk) begin
        if (iq_rd) iq_ptr <= iq_ptr + 1;
        if (n_rd)  n_ptr  <= n_ptr + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: plain, 1: IQ gap, 2: ready toggling, 3: spurious start mid-run
    task automatic run_user(input int a, input int rt, input int mode, input string tag);
        int biq, bn, beats, dones, done_cyc, first_cyc, rte, cyc, r, ni;
        logic [31:0] ei, eq, en;
        logic [1:0]  ev;
        logic        prev_empty;
        logic        finished;
        rte = (rt == 0) ? 1 : rt;
        beats = 0; dones = 0; done_cyc = -1; first_cyc = -1; cyc = 0;
        prev_empty = 1'b0; finished = 1'b0;
        @(negedge clk);
        biq = iq_ptr; bn = n_ptr;
        start = 1'b1; amt = 16'(a); rate = 16'(rt); ready = 1'b1; iq_empty = 1'b0;
        while (!finished) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            amt   = 16'(a);
            if (mode == 3 && cyc == 50) begin
                start = 1'b1;
                amt   = 16'd5;
            end
            ready    = (mode == 2) ? (cyc % 2 == 1) : 1'b1;
            iq_empty = (mode == 1 && cyc >= 100 && cyc <= 138);
            #1;
            if (cyc == 1) chk({tag, "_busy_c1"}, busy, (a > 0));
            if (iq_empty) chk({tag, "_iq_pop_empty"}, iq_rd, 1'b0);
            if (prev_empty) chk({tag, "_strobe_gap"}, strobe, 1'b0);
            if (mode == 3 && cyc == 51) chk({tag, "_start_err"}, serr, 1'b1);
            if (mode == 3 && cyc == 52) chk({tag, "_start_err_off"}, serr, 1'b0);
            if (strobe) begin
                ei = '0; eq = '0; en = '0; ev = '0;
                for (int k = 0; k < 2; k++) begin
                    r = beats * 2 + k;
                    if (r < a) begin
                        ni = r / rte;
                        ev[k] = 1'b1;
                        ei[k*16 +: 16] = smp(biq + r / 4, 2 * (r % 4));
                        eq[k*16 +: 16] = smp(biq + r / 4, 2 * (r % 4) + 1);
                        en[k*16 +: 16] = smp(bn + ni / 8, ni % 8);
                    end
                end
                chk({tag, "_beat_i"}, oi, ei);
                chk({tag, "_beat_q"}, oq, eq);
                chk({tag, "_beat_n"}, on, en);
                chk({tag, "_beat_v"}, ov, ev);
                if (first_cyc < 0) first_cyc = cyc;
                if (beats == 0) begin b0_i = oi; b0_q = oq; b0_n = on; b0_v = ov; end
                if (beats == 1) begin b1_i = oi; b1_n = on; b1_v = ov; end
                if (ready) beats++;
            end
            if (done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            prev_empty = iq_empty;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) finished = 1'b1;
            if (cyc >= 4000) begin
                chk({tag, "_timeout_done"}, dones, 1);
                finished = 1'b1;
            end
        end
        chk({tag, "_beats"}, beats, (a + 1) / 2);
        chk({tag, "_dones"}, dones, 1);
        chk({tag, "_iq_pops"}, iq_ptr - biq, (a + 3) / 4);
        chk({tag, "_noise_pops"}, n_ptr - bn, (a == 0) ? 0 : ((a - 1) / rte) / 8 + 1);
        if (a == 0) chk({tag, "_done_latency"}, done_cyc, 2);
        else chk({tag, "_first_strobe_latency"}, first_cyc, 3);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b1; iq_empty = 1'b0; noise_empty = 1'b0;
        amt = '0; rate = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_strobe", strobe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_iq_rd", iq_rd, 1'b0);
        chk("rst_n_rd", n_rd, 1'b0);
        chk("rst_valid", ov, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        run_user(1800, 8, 0, "nom");
        chk("nom_b0_i", b0_i, 32'h0022_000C);
        chk("nom_b0_q", b0_q, 32'h0033_0011);
        chk("nom_b0_n", b0_n, 32'h000C_000C);

        run_user(1800, 8, 1, "gap");
        run_user(1800, 8, 2, "rdy");

        run_user(3, 1, 0, "small");
        chk("small_b0_v", b0_v, 2'b11);
        chk("small_b0_n0", b0_n[7:0], 8'h0C);
        chk("small_b0_n1", b0_n[23:16], 8'h11);
        chk("small_b1_v", b1_v, 2'b01);
        chk("small_b1_n0", b1_n[7:0], 8'h22);
        chk("small_b1_n1_zero", b1_n[31:16], 16'h0000);
        chk("small_b1_i1_zero", b1_i[31:16], 16'h0000);

        run_user(0, 8, 0, "zero");
        run_user(1800, 8, 3, "serr");

        // Abort a run with reset, then confirm a clean restart.
        @(negedge clk);
        start = 1'b1; amt = 16'd1800; rate = 16'd8; ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_iq_rd", iq_rd, 1'b0);
        chk("rstmid_n_rd", n_rd, 1'b0);
        @(negedge clk);
        #1;
        chk("rstmid_strobe", strobe, 1'b0);
        chk("rstmid_i", oi, 32'h0);
        chk("rstmid_q", oq, 32'h0);
        chk("rstmid_n", on, 32'h0);
        chk("rstmid_valid", ov, 2'b00);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_done", done, 1'b0);
        chk("rstmid_serr", serr, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("rstmid_no_done", done, 1'b0);
        end
        run_user(4, 8, 0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
